// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: CPU request/response handshakes plus the data-memory port of the load/store controller.
// master: CPU/memory side; slave: lsu_ctrl side.
interface lsu_ctrl_if #(parameter int N = 64);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_rdata;
    logic         resp_fault;
    logic         readtype;
    logic [1:0]   memwrite;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [N-1:0] readdata;
    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, readtype, memwrite, dataadr, writedata
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, readdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, readtype, memwrite, dataadr, writedata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store controller between the CPU and a 64-bit big-endian data memory.
// Ports: i_clk, i_reset (sync, active high), bus (lsu_ctrl_if.slave: request/response handshakes
// and memory readtype/memwrite/dataadr/writedata/readdata).
// Option: LSU_ALIGN_CHECK_EN reports misaligned word/doubleword accesses as faults instead of
// silently clearing the low address bits.
module lsu_ctrl #(parameter int N = 64) (
    input logic       i_clk,
    input logic       i_reset,
    lsu_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2;
    localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LW = 3'd2, OP_LWU = 3'd3,
                           OP_LD = 3'd4, OP_SB = 3'd5, OP_SW = 3'd6, OP_SD = 3'd7;
    logic [1:0]   r_state;
    logic [2:0]   r_op;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_rdata;
    logic         r_fault;
    logic         w_accept, w_access, w_word, w_dword, w_mis;
    logic [31:0]  w_w;
    logic [4:0]   w_sh;
    logic [7:0]   w_b;
    logic [N-1:0] w_ld;
    assign w_word   = r_op == OP_LW || r_op == OP_LWU || r_op == OP_SW;
    assign w_dword  = r_op == OP_LD || r_op == OP_SD;
    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_access = r_state == S_ACCESS && !i_reset;
`ifdef LSU_ALIGN_CHECK_EN
    assign w_mis       = (w_word && |r_addr[1:0]) || (w_dword && |r_addr[2:0]);
    assign bus.dataadr = r_addr;
`else
    assign w_mis       = 1'b0;
    assign bus.dataadr = {r_addr[N-1:3], r_addr[2] & ~w_dword, r_addr[1:0] & ~{2{w_word | w_dword}}};
`endif
    // Memory has already selected the word by addr[2]; byte 0 of a word is its most significant byte.
    assign w_w  = bus.readdata[31:0];
    assign w_sh = {~r_addr[1:0], 3'b000};
    assign w_b  = w_w[w_sh +: 8];
    always_comb begin
        w_ld = r_op == OP_LB  ? {{(N-8){w_b[7]}}, w_b} :
               r_op == OP_LBU ? {{(N-8){1'b0}}, w_b} :
               r_op == OP_LW  ? {{(N-32){w_w[31]}}, w_w} :
               r_op == OP_LWU ? {{(N-32){1'b0}}, w_w} :
               r_op == OP_LD  ? bus.readdata : '0;
    end
    assign bus.req_ready  = r_state == S_IDLE && !i_reset;
    assign bus.resp_valid = r_state == S_RESP && !i_reset;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_fault = r_fault;
    assign bus.writedata  = r_wdata;
    assign bus.readtype   = w_access && r_op == OP_LD;
    // Gating with reset inside w_access guarantees no partial write when reset hits ACCESS.
    assign bus.memwrite   = (!w_access || w_mis) ? 2'd0 :
                            r_op == OP_SD ? 2'd3 : r_op == OP_SB ? 2'd2 : r_op == OP_SW ? 2'd1 : 2'd0;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_ACCESS;
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end else if (r_state == S_ACCESS) begin
            r_state <= S_RESP;
            r_rdata <= w_mis ? '0 : w_ld;
            r_fault <= w_mis;
        end else if (r_state == S_RESP && bus.resp_ready) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus random load/store checks of lsu_ctrl against a byte-array reference memory.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [63:0] dm [16];
    logic [7:0]  rm [128];
    logic [3:0]  idx;
    logic [63:0] got;

    lsu_ctrl_if bus ();
    lsu_ctrl dut (.i_clk(clk), .i_reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign idx = bus.dataadr[6:3];
    assign bus.readdata = bus.readtype ? dm[idx] :
                          {dm[idx ^ 4'd1][63:32], bus.dataadr[2] ? dm[idx][31:0] : dm[idx][63:32]};

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 16; i++) dm[i] <= {$urandom, $urandom};
        end else if (bus.memwrite == 2'd3) begin
            dm[idx] <= bus.writedata;
        end else if (bus.memwrite == 2'd1) begin
            if (bus.dataadr[2]) dm[idx][31:0] <= bus.writedata[31:0];
            else dm[idx][63:32] <= bus.writedata[31:0];
        end else if (bus.memwrite == 2'd2) begin
            dm[idx][8*(7-int'(bus.dataadr[2:0])) +: 8] <= bus.writedata[7:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed big-endian memory, access size n, low bits dropped or flagged.
    function automatic void model(input logic [2:0] op, input logic [63:0] a, output logic [63:0] adr,
                                  output logic mis, output logic [1:0] mw, output logic [63:0] res, output int n);
        int ea;
        n = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 : (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 4 : 8;
`ifdef LSU_ALIGN_CHECK_EN
        adr = a;
        mis = (a % 64'(n)) != 0;
`else
        adr = a - (a % 64'(n));
        mis = 1'b0;
`endif
        ea = int'(adr[6:0]);
        mw = (op < 3'd5 || mis) ? 2'd0 : op == 3'd5 ? 2'd2 : op == 3'd6 ? 2'd1 : 2'd3;
        res = '0;
        if (!mis && op < 3'd5) begin
            for (int i = 0; i < n; i++) res = {res[55:0], rm[ea+i]};
            if (op == 3'd0) res = 64'($signed(res[7:0]));
            if (op == 3'd2) res = 64'($signed(res[31:0]));
        end
    endfunction

    task automatic rnd_req();
        bus.req_valid = 1'($urandom);
        bus.req_op    = 3'($urandom);
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
    endtask

    task automatic xact(input logic [2:0] op, input logic [63:0] a, input logic [63:0] wd,
                        input int hold, output logic [63:0] res_out);
        logic [63:0] adr, res;
        logic mis;
        logic [1:0] mw;
        int n;
        model(op, a, adr, mis, mw, res, n);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.resp_ready = 1'b0;
        #1;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        rnd_req();
        chk("memwrite", 64'(bus.memwrite), 64'(mw));
        chk("readtype", 64'(bus.readtype), 64'(op == 3'd4));
        chk("dataadr", bus.dataadr, adr);
        chk("writedata", bus.writedata, wd);
        chk("req_ready_access", 64'(bus.req_ready), 64'd0);
        chk("resp_valid_access", 64'(bus.resp_valid), 64'd0);
        if (op >= 3'd5 && !mis)
            for (int i = 0; i < n; i++) rm[int'(adr[6:0])+i] = wd[8*(n-1-i) +: 8];
        @(posedge clk); #1;
        rnd_req();
        res_out = bus.resp_rdata;
        chk("resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("resp_rdata", bus.resp_rdata, res);
        chk("resp_fault", 64'(bus.resp_fault), 64'(mis));
        chk("req_ready_resp", 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            rnd_req();
            chk("hold_valid", 64'(bus.resp_valid), 64'd1);
            chk("hold_rdata", bus.resp_rdata, res);
            chk("hold_fault", 64'(bus.resp_fault), 64'(mis));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
            chk("hold_memwrite", 64'(bus.memwrite), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("after_hs_valid", 64'(bus.resp_valid), 64'd0);
        chk("after_hs_ready", 64'(bus.req_ready), 64'd1);
        chk("after_hs_memwrite", 64'(bus.memwrite), 64'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        init = 1'b0;
        for (int i = 0; i < 128; i++) rm[i] = dm[i/8][8*(7-i%8) +: 8];
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
        chk("rst_memwrite", 64'(bus.memwrite), 64'd0);
        chk("rst_readtype", 64'(bus.readtype), 64'd0);
        chk("rst_dataadr", bus.dataadr, 64'd0);
        chk("rst_writedata", bus.writedata, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

        xact(3'd7, 64'h10, 64'h0123456789ABCDEF, 0, got);
        xact(3'd4, 64'h10, 64'h0, 0, got);
        chk("ld_after_sd", got, 64'h0123456789ABCDEF);
        xact(3'd0, 64'h13, 64'h0, 1, got);
        xact(3'd1, 64'h13, 64'h0, 0, got);
        xact(3'd0, 64'h14, 64'h0, 0, got);
        chk("lb_0x14", got, 64'hFFFFFFFFFFFFFF89);
        xact(3'd1, 64'h14, 64'h0, 0, got);
        chk("lbu_0x14", got, 64'h89);
        xact(3'd2, 64'h14, 64'h0, 0, got);
        chk("lw_0x14", got, 64'hFFFFFFFF89ABCDEF);
        xact(3'd3, 64'h10, 64'h0, 0, got);
        chk("lwu_0x10", got, 64'h01234567);
        xact(3'd5, 64'h16, 64'h5A, 0, got);
        xact(3'd4, 64'h10, 64'h0, 0, got);
        chk("ld_after_sb", got, 64'h0123456789AB5AEF);
        xact(3'd6, 64'h12, 64'hCAFEBABE, 5, got);
        xact(3'd4, 64'h10, 64'h0, 0, got);

        // Reset during ACCESS of a store: no write, no response.
        bus.req_valid = 1'b1;
        bus.req_op = 3'd7;
        bus.req_addr = 64'h20;
        bus.req_wdata = 64'hDEADBEEF00C0FFEE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("sd_access_memwrite", 64'(bus.memwrite), 64'd3);
        reset = 1'b1;
        #1;
        chk("rst_access_memwrite", 64'(bus.memwrite), 64'd0);
        @(posedge clk); #1;
        chk("rst_access_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_access_req_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
            chk("post_rst_dataadr", bus.dataadr, 64'd0);
            @(posedge clk); #1;
        end
        xact(3'd4, 64'h20, 64'h0, 0, got);

        for (int t = 0; t < 60; t++)
            xact(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)), got);
        for (int t = 0; t < 16; t++)
            xact(3'd4, 64'(t * 8), 64'h0, 0, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
